// File: rtl/regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_pkg
// Brief    : Shared types and helpers for the multi-port register file.
//            Optional feature macro: REGFILE_MP_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_mp_pkg;

    typedef enum logic [0:0] {
        ST_CLR = 1'b0,
        ST_RUN = 1'b1
    } state_e;

    localparam int c_NUM_RD_MIN = 1;
    localparam int c_NUM_RD_MAX = 4;

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       be
    );
        return be ? new_b : old_b;
    endfunction

    // Even parity: the stored bit makes the 9-bit group XOR to zero.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

    function automatic bit num_rd_legal(input int n);
        return (n >= c_NUM_RD_MIN) && (n <= c_NUM_RD_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_mp_rdport.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_rdport
// Brief    : One registered read port: write-first bypass, zero-register
//            force, valid strobe and (REGFILE_MP_PARITY_EN) parity check.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp_rdport
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG0 = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    input  logic [DATA_W-1:0]     mem_word_i,
`ifdef REGFILE_MP_PARITY_EN
    input  logic [DATA_W/8-1:0]   mem_par_i,
    output logic                  par_err_o,
`endif
    input  logic                  wr_fire_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic [DATA_W/8-1:0]   wr_be_i,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  rd_valid_o
);

    localparam int NB = DATA_W / 8;

    logic              hit_w;
    logic              zero_w;
    logic              rd_fire_w;
    logic [DATA_W-1:0] word_w;
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_d;
    logic              rd_valid_q;

    // wr_fire_i is already false for dropped writes, so no bypass on those.
    assign hit_w     = wr_fire_i && (wr_addr_i == rd_addr_i);
    assign zero_w    = (ZERO_REG0 != 0) && (rd_addr_i == '0);
    assign rd_fire_w = run_i && rd_en_i;

    always_comb begin
        word_w = mem_word_i;
        for (int k = 0; k < NB; k++) begin
            word_w[8*k +: 8] = byte_merge(mem_word_i[8*k +: 8],
                                          wr_data_i[8*k +: 8],
                                          hit_w && wr_be_i[k]);
        end
        if (zero_w) begin
            word_w = '0;
        end
    end

    assign rd_data_d  = rd_fire_w ? word_w : rd_data_q;
    assign rd_valid_d = rd_fire_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

`ifdef REGFILE_MP_PARITY_EN
    logic [NB-1:0] byte_err_w;
    logic          par_err_d;
    logic          par_err_q;

    // Bypassed bytes carry freshly generated parity and cannot mismatch.
    always_comb begin
        byte_err_w = '0;
        for (int k = 0; k < NB; k++) begin
            byte_err_w[k] = (byte_parity(mem_word_i[8*k +: 8]) ^ mem_par_i[k])
                            && !(hit_w && wr_be_i[k]);
        end
        if (zero_w) begin
            byte_err_w = '0;
        end
    end

    assign par_err_d = rd_fire_w && (|byte_err_w);

    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err_o = par_err_q;
`endif

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Parametrised multi-read-port register file with byte enables,
//            write-first bypass, hardwired zero register and a self-clearing
//            reset sequencer. Optional macro: REGFILE_MP_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG0 = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic [DATA_W/8-1:0]        wr_be_i,
    input  logic [NUM_RD-1:0]          rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          rd_valid_o,
`ifdef REGFILE_MP_PARITY_EN
    output logic [NUM_RD-1:0]          par_err_o,
`endif
    output logic                       busy_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    generate
        if (!num_rd_legal(NUM_RD) || ((DATA_W % 8) != 0)) begin : g_param_check
            $error("regfile_mp: NUM_RD must be 1..4 and DATA_W a multiple of 8");
        end
    endgenerate

    state_e            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              busy_q;

    logic              run_w;
    logic              clr_we_w;
    logic              wr_fire_w;
    logic [DATA_W-1:0] wr_word_w;

    logic [DATA_W-1:0] mem_q [DEPTH];
`ifdef REGFILE_MP_PARITY_EN
    logic [NB-1:0]     par_q [DEPTH];
    logic [NB-1:0]     wr_par_w;
`endif

    // Clear sequencer: one zero write per cycle, then hand over to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_CLR: begin
                    clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    if (&clr_cnt_q) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_CLR;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign run_w     = (state_q == ST_RUN);
    assign clr_we_w  = (state_q == ST_CLR) && !rst;
    assign wr_fire_w = run_w && !rst && we_i && (wr_be_i != '0)
                       && !((ZERO_REG0 != 0) && (wr_addr_i == '0));

    always_comb begin
        wr_word_w = mem_q[wr_addr_i];
        for (int k = 0; k < NB; k++) begin
            wr_word_w[8*k +: 8] = byte_merge(mem_q[wr_addr_i][8*k +: 8],
                                             wr_data_i[8*k +: 8],
                                             wr_be_i[k]);
        end
    end

`ifdef REGFILE_MP_PARITY_EN
    always_comb begin
        wr_par_w = '0;
        for (int k = 0; k < NB; k++) begin
            wr_par_w[k] = byte_parity(wr_word_w[8*k +: 8]);
        end
    end
`endif

    // Zero words have zero even parity, so the clear leaves parity consistent.
    always_ff @(posedge clk) begin
        if (clr_we_w) begin
            mem_q[clr_cnt_q] <= '0;
`ifdef REGFILE_MP_PARITY_EN
            par_q[clr_cnt_q] <= '0;
`endif
        end else if (wr_fire_w) begin
            mem_q[wr_addr_i] <= wr_word_w;
`ifdef REGFILE_MP_PARITY_EN
            par_q[wr_addr_i] <= wr_par_w;
`endif
        end
    end

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rdport
            logic [ADDR_W-1:0] addr_w;
            assign addr_w = rd_addr_i[i*ADDR_W +: ADDR_W];

            regfile_mp_rdport #(
                .DATA_W    (DATA_W),
                .ADDR_W    (ADDR_W),
                .ZERO_REG0 (ZERO_REG0)
            ) u_rdport (
                .clk        (clk),
                .rst        (rst),
                .run_i      (run_w),
                .rd_en_i    (rd_en_i[i]),
                .rd_addr_i  (addr_w),
                .mem_word_i (mem_q[addr_w]),
`ifdef REGFILE_MP_PARITY_EN
                .mem_par_i  (par_q[addr_w]),
                .par_err_o  (par_err_o[i]),
`endif
                .wr_fire_i  (wr_fire_w),
                .wr_addr_i  (wr_addr_i),
                .wr_data_i  (wr_data_i),
                .wr_be_i    (wr_be_i),
                .rd_data_o  (rd_data_o[i*DATA_W +: DATA_W]),
                .rd_valid_o (rd_valid_o[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire
